// File: rtl/trolley_system_button_poller.sv
// Avalon-MM initiator for the button PIO: programs the irq mask, reads the data register on irq
// or periodic poll, debounces the sample and publishes a clean level, strobes and press count.
module trolley_system_button_poller #(
    parameter logic [31:0] IRQ_MASK_INIT   = 32'h1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned POLL_CYCLES     = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        pio_irq,
    input  logic        cfg_mask_wr,
    input  logic        cfg_mask,
    output logic        btn_level,
    output logic        btn_press,
    output logic        btn_release,
    output logic [15:0] press_count,
    output logic        busy
);

    localparam logic [31:0] POLL_RELOAD = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] DEB_RELOAD  = 32'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StInitWr, StIdle, StMaskWr, StRd1Req, StRd1Cap, StWait, StRd2Req, StRd2Cap
    } state_e;

    state_e      state;
    logic [31:0] poll_cnt;
    logic [31:0] deb_cnt;
    logic        s1;

    // Only bit 0 of the data register carries the button.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StInitWr;
            avm_address    <= 2'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 32'd0;
            btn_level      <= 1'b0;
            btn_press      <= 1'b0;
            btn_release    <= 1'b0;
            press_count    <= 16'd0;
            busy           <= 1'b1;
            poll_cnt       <= 32'd0;
            deb_cnt        <= 32'd0;
            s1             <= 1'b0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            btn_press      <= 1'b0;
            btn_release    <= 1'b0;
            busy           <= 1'b1;
            unique case (state)
                // First cycle after reset drives the write; the second moves on to IDLE.
                StInitWr: begin
                    if (!avm_chipselect) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd2;
                        avm_writedata  <= IRQ_MASK_INIT;
                    end else begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        poll_cnt <= POLL_RELOAD;
                    end
                end
                StIdle: begin
                    if (cfg_mask_wr) begin
                        state          <= StMaskWr;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd2;
                        avm_writedata  <= {31'b0, cfg_mask};
                    end else if ((pio_irq && !btn_level) || (btn_level && poll_cnt == 32'd0)) begin
                        state          <= StRd1Req;
                        avm_chipselect <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (btn_level) poll_cnt <= poll_cnt - 32'd1;
                    end
                end
                StMaskWr: begin
                    state    <= StIdle;
                    busy     <= 1'b0;
                    poll_cnt <= POLL_RELOAD;
                end
                StRd1Req: state <= StRd1Cap;
                StRd1Cap: begin
                    s1 <= avm_readdata[0];
                    if (avm_readdata[0] == btn_level) begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        poll_cnt <= POLL_RELOAD;
                    end else begin
                        state   <= StWait;
                        deb_cnt <= DEB_RELOAD;
                    end
                end
                StWait: begin
                    if (deb_cnt == 32'd0) begin
                        state          <= StRd2Req;
                        avm_chipselect <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt - 32'd1;
                    end
                end
                StRd2Req: state <= StRd2Cap;
                StRd2Cap: begin
                    state    <= StIdle;
                    busy     <= 1'b0;
                    poll_cnt <= POLL_RELOAD;
                    if (avm_readdata[0] == s1) begin
                        btn_level <= s1;
                        if (s1) begin
                            btn_press   <= 1'b1;
                            press_count <= press_count + 16'd1;
                        end else begin
                            btn_release <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trolley_system_button_poller.sv
// Bench: PIO responder model, procedural reference model of the poller and per-cycle compare.
module tb_trolley_system_button_poller;

    localparam int unsigned DEB       = 4;
    localparam int unsigned POLL      = 8;
    localparam logic [31:0] MASK_INIT = 32'h1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        pio_irq;
    logic        cfg_mask_wr = 1'b0, cfg_mask = 1'b0;
    logic        btn_level, btn_press, btn_release, busy;
    logic [15:0] press_count;

    logic in_port  = 1'b0;
    logic pio_mask = 1'b0;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle, maintained by the model.
    logic        e_cs, e_wn, e_busy, e_lvl, e_press, e_rel;
    logic [1:0]  e_addr;
    logic [31:0] e_wd;
    logic [15:0] e_cnt;
    logic        cmp_on = 1'b0;

    trolley_system_button_poller #(
        .IRQ_MASK_INIT  (MASK_INIT),
        .DEBOUNCE_CYCLES(DEB),
        .POLL_CYCLES    (POLL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .pio_irq       (pio_irq),
        .cfg_mask_wr   (cfg_mask_wr),
        .cfg_mask      (cfg_mask),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .press_count   (press_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // PIO responder: registered readdata with junk upper bits, mask register, level irq.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n && avm_address == 2'd0)
            avm_readdata <= ($urandom() & 32'hFFFF_FFFE) | {31'b0, in_port};
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
            pio_mask <= avm_writedata[0];
    end
    assign pio_irq = in_port & pio_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_reset_exp();
        e_cs = 1'b0; e_wn = 1'b1; e_addr = 2'd0; e_wd = 32'd0; e_busy = 1'b1;
        e_lvl = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_cnt = 16'd0;
    endtask

    task automatic tick(output bit ab);
        @(posedge clk or negedge reset_n);
        ab = !reset_n;
    endtask

    // Walks through the poller's behaviour as a sequence of bus transactions; returns on reset.
    task automatic model_session();
        bit ab, go_rd, go_mw, m, s1, s2;
        int poll;
        tick(ab); if (ab) return;
        e_cs = 1'b1; e_wn = 1'b0; e_addr = 2'd2; e_wd = MASK_INIT; e_busy = 1'b1;
        tick(ab); if (ab) return;
        forever begin
            poll = POLL; go_rd = 1'b0; go_mw = 1'b0; m = 1'b0;
            while (!go_rd && !go_mw) begin
                e_cs = 1'b0; e_wn = 1'b1; e_addr = 2'd0; e_busy = 1'b0;
                tick(ab); if (ab) return;
                e_press = 1'b0; e_rel = 1'b0;
                if (cfg_mask_wr) begin
                    go_mw = 1'b1; m = cfg_mask;
                end else if (pio_irq && !e_lvl) begin
                    go_rd = 1'b1;
                end else if (e_lvl) begin
                    poll--;
                    if (poll == 0) go_rd = 1'b1;
                end
            end
            e_busy = 1'b1;
            if (go_mw) begin
                e_cs = 1'b1; e_wn = 1'b0; e_addr = 2'd2; e_wd = {31'b0, m};
                tick(ab); if (ab) return;
            end else begin
                e_cs = 1'b1;
                tick(ab); if (ab) return;
                e_cs = 1'b0;
                tick(ab); if (ab) return;
                s1 = avm_readdata[0];
                if (s1 != e_lvl) begin
                    repeat (DEB) begin
                        tick(ab); if (ab) return;
                    end
                    e_cs = 1'b1;
                    tick(ab); if (ab) return;
                    e_cs = 1'b0;
                    tick(ab); if (ab) return;
                    s2 = avm_readdata[0];
                    if (s2 == s1) begin
                        e_lvl = s1;
                        if (s1) begin
                            e_press = 1'b1;
                            e_cnt   = e_cnt + 16'd1;
                        end else begin
                            e_rel = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #2;
        forever begin
            set_reset_exp();
            wait (reset_n === 1'b1);
            model_session();
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("chipselect", 32'(avm_chipselect), 32'(e_cs));
            chk("write_n", 32'(avm_write_n), 32'(e_wn));
            chk("address", 32'(avm_address), 32'(e_addr));
            chk("writedata", avm_writedata, e_wd);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("btn_level", 32'(btn_level), 32'(e_lvl));
            chk("btn_press", 32'(btn_press), 32'(e_press));
            chk("btn_release", 32'(btn_release), 32'(e_rel));
            chk("press_count", 32'(press_count), 32'(e_cnt));
        end
    end

    task automatic wait_evt(input string name, input bit rel, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = rel ? btn_release : btn_press;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 cmp_on = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        // Reset release: one mask write, then idle.
        @(negedge clk);
        chk("init_cs", 32'(avm_chipselect), 32'd1);
        chk("init_wn", 32'(avm_write_n), 32'd0);
        chk("init_addr", 32'(avm_address), 32'd2);
        chk("init_wd", avm_writedata, 32'h1);
        @(negedge clk);
        chk("post_init_cs", 32'(avm_chipselect), 32'd0);
        chk("post_init_busy", 32'(busy), 32'd0);
        idle_cycles(3);

        // Clean press via irq.
        in_port = 1'b1;
        wait_evt("press_seen", 1'b0, 40);
        chk("press_level", 32'(btn_level), 32'd1);
        chk("press_count1", 32'(press_count), 32'd1);
        @(negedge clk);
        chk("press_one_cycle", 32'(btn_press), 32'd0);

        // Release found by polling.
        in_port = 1'b0;
        wait_evt("release_seen", 1'b1, 60);
        chk("release_level", 32'(btn_level), 32'd0);
        idle_cycles(4);

        // Two-cycle glitch must be rejected.
        in_port = 1'b1;
        idle_cycles(2);
        in_port = 1'b0;
        idle_cycles(20);
        chk("glitch_level", 32'(btn_level), 32'd0);
        chk("glitch_count", 32'(press_count), 32'd1);

        // Mask off: press goes unnoticed; mask back on: detected.
        cfg_mask_wr = 1'b1; cfg_mask = 1'b0;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        idle_cycles(2);
        in_port = 1'b1;
        idle_cycles(30);
        chk("masked_level", 32'(btn_level), 32'd0);
        cfg_mask_wr = 1'b1; cfg_mask = 1'b1;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        wait_evt("unmasked_press", 1'b0, 40);
        chk("unmasked_count", 32'(press_count), 32'd2);
        in_port = 1'b0;
        wait_evt("unmasked_release", 1'b1, 60);
        idle_cycles(4);

        // Reset in the middle of the debounce wait.
        in_port = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_wn", 32'(avm_write_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_count", 32'(press_count), 32'd0);
        in_port = 1'b0;
        idle_cycles(2);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reinit_cs", 32'(avm_chipselect), 32'd1);
        chk("reinit_addr", 32'(avm_address), 32'd2);
        chk("reinit_wd", avm_writedata, 32'h1);
        idle_cycles(4);

        // Random button activity with occasional mask rewrites.
        for (int i = 0; i < 120; i++) begin
            in_port = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 30)); k++) begin
                @(negedge clk);
                cfg_mask_wr = ($urandom_range(0, 15) == 0);
                cfg_mask    = ($urandom_range(0, 3) != 0);
            end
        end
        cfg_mask_wr = 1'b0;
        in_port = 1'b0;
        idle_cycles(40);
        cfg_mask_wr = 1'b1; cfg_mask = 1'b1;
        @(negedge clk);
        cfg_mask_wr = 1'b0;
        idle_cycles(4);

        // Counter wrap from 16'hFFFF.
        #2;
        force dut.press_count = 16'hFFFF;
        e_cnt = 16'hFFFF;
        #1 release dut.press_count;
        @(negedge clk);
        in_port = 1'b1;
        wait_evt("wrap_press", 1'b0, 40);
        chk("wrap_count", 32'(press_count), 32'd0);
        in_port = 1'b0;
        wait_evt("wrap_release", 1'b1, 60);
        idle_cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
